// File: rtl/riscv_ifu_prefetch.sv
// Instruction prefetch unit: issues sequential icache reads and queues responses for decode.
// Define RISCV_IFU_FAULT_EN to store icache_error_i per entry and flag faulted fetches.
`ifndef INST_FAULT
`define INST_FAULT 32'h0000_0000
`endif

module riscv_ifu_prefetch #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [31:0] icache_inst_i,
    input  logic        icache_error_i,
    output logic        icache_flush_o,
    input  logic        fetch_branch_i,
    input  logic [31:0] fetch_branch_pc_i,
    input  logic        fetch_invalidate_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_fault_o,
    input  logic        fetch_accept_i
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic             r_active;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_resp_pc;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [31:0]      r_mem_inst [FIFO_DEPTH];
    logic [31:0]      r_mem_pc   [FIFO_DEPTH];

    logic             w_req_acc;
    logic             w_resp;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W:0]   w_occupancy;

    // Reads in flight already own a FIFO slot, so the queue can never overflow.
    assign w_occupancy = {1'b0, r_inflight} + {1'b0, r_count};
    assign icache_rd_o = r_active && !fetch_branch_i
                         && (r_inflight < CNT_W'(MAX_OUTSTANDING))
                         && (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign icache_pc_o    = r_fetch_pc;
    assign icache_flush_o = fetch_invalidate_i;

    assign w_req_acc = icache_rd_o && icache_accept_i;
    // Stray responses (e.g. reads abandoned by a reset) never touch the counters.
    assign w_resp    = icache_valid_i && r_active && (r_inflight != '0);
    assign w_push    = w_resp && !fetch_branch_i && (r_drop == '0);
    assign w_pop     = fetch_valid_o && fetch_accept_i;

    assign fetch_valid_o = (r_count != '0) && !fetch_branch_i;
    assign fetch_pc_o    = r_mem_pc[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active   <= 1'b0;
            r_fetch_pc <= 32'd0;
            r_resp_pc  <= 32'd0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (fetch_branch_i) begin
                r_active <= 1'b1;
            end

            if (fetch_branch_i) begin
                r_fetch_pc <= fetch_branch_pc_i;
            end else if (w_req_acc) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (w_req_acc && !w_resp) begin
                r_inflight <= r_inflight + CNT_W'(1);
            end else if (!w_req_acc && w_resp) begin
                r_inflight <= r_inflight - CNT_W'(1);
            end

            if (fetch_branch_i) begin
                r_drop <= r_inflight - CNT_W'(w_resp);
            end else if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - CNT_W'(1);
            end

            if (fetch_branch_i) begin
                r_resp_pc <= fetch_branch_pc_i;
                r_count   <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
            end else begin
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= icache_inst_i;
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

`ifdef RISCV_IFU_FAULT_EN
    logic r_mem_err [FIFO_DEPTH];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_err[r_wr_ptr] <= icache_error_i;
        end
    end

    assign fetch_instr_o = r_mem_err[r_rd_ptr] ? `INST_FAULT : r_mem_inst[r_rd_ptr];
    assign fetch_fault_o = fetch_valid_o && r_mem_err[r_rd_ptr];
`else
    logic w_unused;

    assign w_unused      = icache_error_i;
    assign fetch_instr_o = r_mem_inst[r_rd_ptr];
    assign fetch_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_ifu_prefetch.sv
// Scoreboard bench for riscv_ifu_prefetch: icache model, decoupled fetch monitor, directed phases.
`ifndef INST_FAULT
`define INST_FAULT 32'h0000_0000
`endif

module tb_riscv_ifu_prefetch;
`ifdef RISCV_IFU_FAULT_EN
    localparam bit FaultEn = 1'b1;
`else
    localparam bit FaultEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_rd;
    logic [31:0] icache_pc;
    logic        icache_accept;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        icache_error;
    logic        icache_flush;
    logic        fetch_branch;
    logic [31:0] fetch_branch_pc;
    logic        fetch_invalidate;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_fault;
    logic        fetch_accept;

    riscv_ifu_prefetch #(
        .FIFO_DEPTH     (4),
        .MAX_OUTSTANDING(2)
    ) u_dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .icache_rd_o       (icache_rd),
        .icache_pc_o       (icache_pc),
        .icache_accept_i   (icache_accept),
        .icache_valid_i    (icache_valid),
        .icache_inst_i     (icache_inst),
        .icache_error_i    (icache_error),
        .icache_flush_o    (icache_flush),
        .fetch_branch_i    (fetch_branch),
        .fetch_branch_pc_i (fetch_branch_pc),
        .fetch_invalidate_i(fetch_invalidate),
        .fetch_valid_o     (fetch_valid),
        .fetch_instr_o     (fetch_instr),
        .fetch_pc_o        (fetch_pc),
        .fetch_fault_o     (fetch_fault),
        .fetch_accept_i    (fetch_accept)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        int          ready;
    } req_t;

    exp_t        exp_q[$];
    req_t        pending[$];
    logic [31:0] acc_log[$];
    exp_t        mon_e;
    req_t        mdl_r;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          xfer_cnt = 0;
    int          cyc      = 0;
    int          max_inf  = 0;
    bit          resp_en;
    logic [31:0] err_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0F00;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic flt);
        exp_t e;
        e.pc    = pc;
        e.fault = flt && FaultEn;
        e.instr = e.fault ? `INST_FAULT : inst_of(pc);
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    // Icache model: in-order responses, at least one cycle after acceptance.
    always @(posedge clk) cyc++;

    always begin
        @(negedge clk);
        #1;
        icache_valid = 1'b0;
        icache_error = 1'b0;
        if (resp_en && pending.size() > 0 && pending[0].ready <= cyc) begin
            mdl_r        = pending.pop_front();
            icache_valid = 1'b1;
            icache_inst  = inst_of(mdl_r.pc);
            icache_error = (mdl_r.pc == err_pc);
        end
        #1;
        if (icache_rd && icache_accept) begin
            mdl_r.pc    = icache_pc;
            mdl_r.ready = cyc + 1;
            pending.push_back(mdl_r);
            acc_log.push_back(icache_pc);
            if (pending.size() > max_inf) max_inf = pending.size();
        end
    end

    // Fetch monitor: a transfer is decided by the values settled mid-cycle.
    always begin
        @(negedge clk);
        #3;
        if (rst_n && fetch_valid && fetch_accept) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fetch: got pc %h, required no transfer", fetch_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check32("fetch_pc", fetch_pc, mon_e.pc);
                check32("fetch_instr", fetch_instr, mon_e.instr);
                check32("fetch_fault", {31'd0, fetch_fault}, {31'd0, mon_e.fault});
            end
        end
    end

    task automatic do_branch(input logic [31:0] pc);
        @(negedge clk);
        fetch_branch    = 1'b1;
        fetch_branch_pc = pc;
        acc_log.delete();
        #4;
        check32("branch_no_rd", {31'd0, icache_rd}, 32'd0);
        check32("branch_no_valid", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        fetch_branch = 1'b0;
    endtask

    task automatic consume(input int n, input string name);
        int  target;
        bit  done;
        target = xfer_cnt + n;
        done   = 1'b0;
        @(negedge clk);
        fetch_accept = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (xfer_cnt >= target) begin
                fetch_accept = 1'b0;
                done         = 1'b1;
            end
        end
        if (!done) begin
            fetch_accept = 1'b0;
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d transfers, required %0d", name,
                     xfer_cnt - (target - n), n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        icache_accept    = 1'b1;
        icache_valid     = 1'b0;
        icache_inst      = 32'd0;
        icache_error     = 1'b0;
        fetch_branch     = 1'b0;
        fetch_branch_pc  = 32'd0;
        fetch_invalidate = 1'b0;
        fetch_accept     = 1'b0;
        resp_en          = 1'b1;
        err_pc           = 32'h0000_0001;

        #2;
        check32("rst_rd", {31'd0, icache_rd}, 32'd0);
        check32("rst_pc", icache_pc, 32'd0);
        check32("rst_valid", {31'd0, fetch_valid}, 32'd0);
        check32("rst_fault", {31'd0, fetch_fault}, 32'd0);
        fetch_invalidate = 1'b1;
        #1 check32("flush_hi", {31'd0, icache_flush}, 32'd1);
        fetch_invalidate = 1'b0;
        #1 check32("flush_lo", {31'd0, icache_flush}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #4 check32("idle_no_rd", {31'd0, icache_rd}, 32'd0);

        // Streaming with decode always accepting.
        exp_push(32'h100, 1'b0);
        exp_push(32'h104, 1'b0);
        exp_push(32'h108, 1'b0);
        do_branch(32'h100);
        consume(3, "stream");

        // Decode stalled: queue fills to depth, then drains in order.
        exp_push(32'h100, 1'b0);
        exp_push(32'h104, 1'b0);
        exp_push(32'h108, 1'b0);
        exp_push(32'h10C, 1'b0);
        do_branch(32'h100);
        repeat (5) @(negedge clk);
        #4;
        check32("hold_valid", {31'd0, fetch_valid}, 32'd1);
        check32("hold_pc_early", fetch_pc, 32'h100);
        repeat (15) @(negedge clk);
        #4;
        check32("full_no_rd", {31'd0, icache_rd}, 32'd0);
        check32("full_reqs", 32'(acc_log.size()), 32'd4);
        check32("hold_pc_late", fetch_pc, 32'h100);
        check32("hold_instr", fetch_instr, inst_of(32'h100));
        consume(4, "drain");

        // Branch with two reads outstanding: both responses dropped.
        repeat (10) @(negedge clk);
        resp_en = 1'b0;
        do_branch(32'h300);
        repeat (2) @(negedge clk);
        #4;
        check32("max_out_no_rd", {31'd0, icache_rd}, 32'd0);
        check32("max_out_pending", 32'(pending.size()), 32'd2);
        exp_push(32'h200, 1'b0);
        exp_push(32'h204, 1'b0);
        do_branch(32'h200);
        resp_en = 1'b1;
        consume(2, "drop2");

        // Branch in the same cycle as the only outstanding response.
        repeat (10) @(negedge clk);
        resp_en = 1'b0;
        do_branch(32'h400);
        resp_en = 1'b1;
        exp_push(32'h200, 1'b0);
        do_branch(32'h200);
        #4;
        check32("redirect_rd", {31'd0, icache_rd}, 32'd1);
        check32("redirect_pc", icache_pc, 32'h200);
        consume(1, "coincide");

        // Bus error on a single entry.
        err_pc = 32'h104;
        exp_push(32'h100, 1'b0);
        exp_push(32'h104, 1'b1);
        exp_push(32'h108, 1'b0);
        do_branch(32'h100);
        consume(3, "fault");
        err_pc = 32'h0000_0001;

        // Address wrap, then reset in the middle of the stream.
        exp_push(32'hFFFF_FFF8, 1'b0);
        exp_push(32'hFFFF_FFFC, 1'b0);
        exp_push(32'h0000_0000, 1'b0);
        do_branch(32'hFFFF_FFF8);
        consume(3, "wrap");
        check32("wrap_req0", acc_at(0), 32'hFFFF_FFF8);
        check32("wrap_req1", acc_at(1), 32'hFFFF_FFFC);
        check32("wrap_req2", acc_at(2), 32'h0000_0000);
        repeat (2) @(negedge clk);
        resp_en = 1'b0;
        repeat (2) @(negedge clk);
        #4 check32("pre_rst_valid", {31'd0, fetch_valid}, 32'd1);
        @(posedge clk);
        #2;
        rst_n            = 1'b0;
        fetch_invalidate = 1'b1;
        #1;
        check32("mid_rst_rd", {31'd0, icache_rd}, 32'd0);
        check32("mid_rst_pc", icache_pc, 32'd0);
        check32("mid_rst_valid", {31'd0, fetch_valid}, 32'd0);
        check32("mid_rst_fault", {31'd0, fetch_fault}, 32'd0);
        check32("mid_rst_flush", {31'd0, icache_flush}, 32'd1);
        fetch_invalidate = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        resp_en = 1'b1;
        repeat (6) @(negedge clk);
        #4;
        check32("post_rst_no_rd", {31'd0, icache_rd}, 32'd0);
        check32("post_rst_no_valid", {31'd0, fetch_valid}, 32'd0);
        check32("post_rst_drained", 32'(pending.size()), 32'd0);
        exp_push(32'h500, 1'b0);
        exp_push(32'h504, 1'b0);
        do_branch(32'h500);
        consume(2, "restart");

        check32("exp_empty", 32'(exp_q.size()), 32'd0);
        check32("max_inflight_ok", {31'd0, (max_inf <= 2)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
